// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl
// Purpose  : Memory-mapped interrupt controller. It latches device interrupt
//            requests into a pending register, with a per-source level/edge
//            mode and a per-source mask. It drives a registered, masked
//            interrupt vector to CP0.
// Ports    : clk     - system clock, rising edge
//            reset   - asynchronous, active-high reset
//            Addr    - bridge word address; only Addr[3:2] is decoded
//            WE      - write enable, already qualified by chip select
//            Din     - write data (bits above NSRC ignored)
//            Dout    - read data, combinational from Addr[3:2]
//            Src     - raw device interrupt requests
//            HInt    - registered masked pending vector to CP0
//            IrqAny  - OR of HInt
//            IrqID   - index of lowest-numbered set HInt bit, 0 when none
// Register map (Addr[3:2]):
//            0 MASK (r/w), 1 PEND (r, write-1-to-clear),
//            2 MODE (r/w, 1 = edge), 3 RAW (r, sampled sources)
// Option   : define IRQ_SYNC_EN to insert a two-flop synchronizer on Src
//            (adds two cycles of latency; RAW then shows synchronized data).
// Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
  parameter int              NSRC     = 6,
  parameter logic [NSRC-1:0] MASK_RST = 6'h3F,
  parameter logic [NSRC-1:0] MODE_RST = 6'h00
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:2]     Addr,
  input  logic            WE,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  input  logic [NSRC-1:0] Src,
  output logic [NSRC-1:0] HInt,
  output logic            IrqAny,
  output logic [2:0]      IrqID
);

  localparam logic [1:0] C_A_MASK = 2'd0;
  localparam logic [1:0] C_A_PEND = 2'd1;
  localparam logic [1:0] C_A_MODE = 2'd2;
  localparam logic [1:0] C_A_RAW  = 2'd3;

  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] srcq_q;
  logic [NSRC-1:0] hint_q, hint_d;

  logic [NSRC-1:0] src_s;   // source as seen by the edge/level logic
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] set_v;
  logic [NSRC-1:0] clr_v;

  // Upper address and data bits are intentionally not decoded.
  logic unused_bits;
  assign unused_bits = ^{Addr[31:4], Din[31:NSRC]};

`ifdef IRQ_SYNC_EN
  logic [NSRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= Src;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = Src;
`endif

  assign rise  = src_s & ~srcq_q;
  assign set_v = (mode_q & rise) | (~mode_q & src_s);

  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    clr_v  = '0;
    if (WE) begin
      case (Addr[3:2])
        C_A_MASK: mask_d = Din[NSRC-1:0];
        C_A_PEND: clr_v  = Din[NSRC-1:0];
        C_A_MODE: mode_d = Din[NSRC-1:0];
        default:  ;  // RAW is read-only
      endcase
    end
    // Set is applied after the clear so a new request wins over a
    // simultaneous software clear of the same bit.
    pend_d = (pend_q & ~clr_v) | set_v;
    // The pending vector reaches HInt one edge after it is latched. The mask
    // being written this cycle applies straight away, so a MASK write shows
    // on HInt at the edge that performs it.
    hint_d = pend_q & mask_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= MASK_RST;
      mode_q <= MODE_RST;
      pend_q <= '0;
      srcq_q <= '0;
      hint_q <= '0;
    end else begin
      mask_q <= mask_d;
      mode_q <= mode_d;
      pend_q <= pend_d;
      srcq_q <= src_s;
      hint_q <= hint_d;
    end
  end

  always_comb begin
    Dout = '0;
    case (Addr[3:2])
      C_A_MASK: Dout[NSRC-1:0] = mask_q;
      C_A_PEND: Dout[NSRC-1:0] = pend_q;
      C_A_MODE: Dout[NSRC-1:0] = mode_q;
      C_A_RAW:  Dout[NSRC-1:0] = srcq_q;
      default:  Dout = '0;
    endcase
  end

  assign HInt   = hint_q;
  assign IrqAny = |hint_q;

  // Scan from the top down so the lowest set bit is the last one assigned.
  always_comb begin
    IrqID = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (hint_q[i]) IrqID = 3'(i);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_ctrl
// Purpose  : Self-checking bench for irq_ctrl. A behavioural register model
//            is compared with the DUT outputs on every falling clock edge.
//            Directed scenarios add hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

  localparam int NSRC = 6;

  logic            clk   = 1'b0;
  logic            reset = 1'b1;
  logic [31:2]     Addr  = '0;
  logic            WE    = 1'b0;
  logic [31:0]     Din   = '0;
  logic [31:0]     Dout;
  logic [NSRC-1:0] Src   = '0;
  logic [NSRC-1:0] w_hint;
  logic            IrqAny;
  logic [2:0]      IrqID;

  int n_checks = 0;
  int n_fail   = 0;

  irq_ctrl #(.NSRC(NSRC)) dut (
    .clk    (clk),
    .reset  (reset),
    .Addr   (Addr),
    .WE     (WE),
    .Din    (Din),
    .Dout   (Dout),
    .Src    (Src),
    .HInt   (w_hint),
    .IrqAny (IrqAny),
    .IrqID  (IrqID)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [NSRC-1:0] m_mask = 6'h3F;
  logic [NSRC-1:0] m_mode = 6'h00;
  logic [NSRC-1:0] m_pend = 6'h00;
  logic [NSRC-1:0] m_raw  = 6'h00;
  logic [NSRC-1:0] m_hint = 6'h00;

  always @(posedge clk or posedge reset) begin
    logic [NSRC-1:0] old_pend;
    if (reset) begin
      m_mask = 6'h3F;
      m_mode = 6'h00;
      m_pend = 6'h00;
      m_raw  = 6'h00;
      m_hint = 6'h00;
    end else begin
      old_pend = m_pend;
      for (int b = 0; b < NSRC; b++) begin
        // Edge sources latch only on a low-to-high step; level sources latch
        // whenever high. A write-1 clear loses to a new request.
        if (m_mode[b]) begin
          if (Src[b] && !m_raw[b]) m_pend[b] = 1'b1;
          else if (WE && Addr[3:2] == 2'd1 && Din[b]) m_pend[b] = 1'b0;
        end else begin
          if (Src[b]) m_pend[b] = 1'b1;
          else if (WE && Addr[3:2] == 2'd1 && Din[b]) m_pend[b] = 1'b0;
        end
      end
      if (WE && Addr[3:2] == 2'd0) m_mask = Din[NSRC-1:0];
      if (WE && Addr[3:2] == 2'd2) m_mode = Din[NSRC-1:0];
      m_hint = old_pend & m_mask;
      m_raw  = Src;
    end
  end

  function automatic logic [2:0] lowest_set(input logic [NSRC-1:0] v);
    for (int b = 0; b < NSRC; b++) begin
      if (v[b]) return 3'(b);
    end
    return 3'd0;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0:    r[NSRC-1:0] = m_mask;
      2'd1:    r[NSRC-1:0] = m_pend;
      2'd2:    r[NSRC-1:0] = m_mode;
      default: r[NSRC-1:0] = m_raw;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    check("model_hint", 32'(w_hint), 32'(m_hint));
    check("model_any", 32'(IrqAny), 32'(|m_hint));
    check("model_id", 32'(IrqID), 32'(lowest_set(m_hint)));
    check("model_dout", Dout, model_read(Addr[3:2]));
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr[3:2] = a;
    Din       = d;
    WE        = 1'b1;
    cyc();
    WE        = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    Addr[3:2] = a;
    #1;
    check(name, Dout, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    rd_check("rst_mask", 2'd0, 32'h3F);
    rd_check("rst_pend", 2'd1, 32'h00);
    rd_check("rst_mode", 2'd2, 32'h00);
    rd_check("rst_raw", 2'd3, 32'h00);
    check("rst_hint", 32'(w_hint), 32'h0);
    check("rst_any", 32'(IrqAny), 32'h0);
    check("rst_id", 32'(IrqID), 32'h0);

    // Level mode
    Src = 6'b000100;
    cyc();
    rd_check("lvl_pend_set", 2'd1, 32'h04);
    check("lvl_hint_lag", 32'(w_hint), 32'h00);
    cyc();
    check("lvl_hint", 32'(w_hint), 32'h04);
    check("lvl_id", 32'(IrqID), 32'd2);
    wr(2'd1, 32'h04);
    rd_check("lvl_clr_while_high", 2'd1, 32'h04);
    Src = 6'b000000;
    cyc();
    rd_check("lvl_pend_held", 2'd1, 32'h04);
    wr(2'd1, 32'h04);
    rd_check("lvl_clr", 2'd1, 32'h00);
    cyc();
    check("lvl_hint_clr", 32'(w_hint), 32'h00);

    // Edge mode; clear on the rising-edge cycle loses to the set
    wr(2'd2, 32'h01);
    rd_check("edge_mode", 2'd2, 32'h01);
    Src = 6'b000001;
    wr(2'd1, 32'h01);
    rd_check("edge_set_wins", 2'd1, 32'h01);
    repeat (4) cyc();
    rd_check("edge_held", 2'd1, 32'h01);
    wr(2'd1, 32'h01);
    rd_check("edge_clr", 2'd1, 32'h00);
    repeat (2) cyc();
    rd_check("edge_no_reset", 2'd1, 32'h00);
    check("edge_hint", 32'(w_hint), 32'h00);
    Src = 6'b000000;
    cyc();

    // Masking
    wr(2'd2, 32'h00);
    wr(2'd0, 32'h00);
    Src = 6'b000010;
    cyc();
    Src = 6'b000000;
    cyc();
    rd_check("mask_pend", 2'd1, 32'h02);
    check("mask_hint0", 32'(w_hint), 32'h00);
    wr(2'd0, 32'h02);
    check("mask_hint_on", 32'(w_hint), 32'h02);
    wr(2'd1, 32'h02);
    cyc();
    check("mask_hint_off", 32'(w_hint), 32'h00);
    wr(2'd0, 32'h3F);

    // Priority
    Src = 6'b101000;
    repeat (2) cyc();
    check("prio_hint", 32'(w_hint), 32'h28);
    check("prio_id", 32'(IrqID), 32'd3);
    check("prio_any", 32'(IrqAny), 32'd1);
    rd_check("prio_raw", 2'd3, 32'h28);
    Src = 6'b100000;
    wr(2'd1, 32'h08);
    cyc();
    check("prio_id5", 32'(IrqID), 32'd5);

    // Asynchronous reset between edges
    Src = 6'b111111;
    repeat (2) cyc();
    rd_check("ar_pend_full", 2'd1, 32'h3F);
    check("ar_hint_full", 32'(w_hint), 32'h3F);
    reset = 1'b1;
    #1;
    check("ar_hint", 32'(w_hint), 32'h00);
    check("ar_any", 32'(IrqAny), 32'h0);
    check("ar_id", 32'(IrqID), 32'h0);
    rd_check("ar_pend", 2'd1, 32'h00);
    Src = 6'b000000;
    #1;
    reset = 1'b0;
    repeat (2) cyc();
    rd_check("ar_pend_after", 2'd1, 32'h00);
    check("ar_hint_after", 32'(w_hint), 32'h00);

    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
